// File: rtl/weight_bias_fetcher_pkg.sv
// Shared definitions for the weight/bias fetcher: FSM state encoding and beat sizing.
package weight_bias_fetcher_pkg;

  localparam int unsigned MEM_DATA_WIDTH_DEFAULT = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned BYTES_PER_BEAT_DEFAULT = bytes_per_beat(MEM_DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/weight_fetch_credit.sv
// Outstanding-beat counter for the weight/bias fetcher: tracks requested-but-not-returned
// beats and answers whether a burst of query_len beats still fits under MAX_OUTSTANDING.
module weight_fetch_credit #(
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_fire,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 ret_valid,
  input  logic [LEN_WIDTH-1:0] query_len,
  output logic                 can_issue,
  output logic                 ret_accept,
  output logic                 credit_empty
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = ((OUT_W > LEN_WIDTH) ? OUT_W : LEN_WIDTH) + 1;

  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  // Returns arriving with nothing outstanding are stale (e.g. after a reset) and dropped.
  assign ret_accept   = ret_valid && (outstanding_q != '0);
  assign credit_empty = (outstanding_q == '0);
  assign can_issue    = (SUM_W'(outstanding_q) + SUM_W'(query_len)) <= SUM_W'(MAX_OUTSTANDING);

  always_comb begin
    outstanding_d = outstanding_q;
    if (cmd_fire) begin
      outstanding_d = outstanding_d + OUT_W'(cmd_len);
    end
    if (ret_accept) begin
      outstanding_d = outstanding_d - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/weight_bias_fetcher.sv
// Weight/bias fetch engine: issues read bursts for a contiguous beat region and forwards
// returned beats to the weight buffer. Define WEIGHT_FETCH_PERF_CNT_EN for perf counters.
module weight_bias_fetcher
  import weight_bias_fetcher_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH  = MEM_DATA_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BEAT_CNT_WIDTH  = 20,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      fetch_start,
  input  logic [ADDR_WIDTH-1:0]     fetch_base_addr,
  input  logic [BEAT_CNT_WIDTH-1:0] fetch_beat_num,
  output logic                      fetch_busy,
  output logic                      fetch_done,
  output logic                      rd_cmd_valid,
  input  logic                      rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0]     rd_cmd_addr,
  output logic [LEN_WIDTH-1:0]      rd_cmd_len,
  input  logic [MEM_DATA_WIDTH-1:0] rd_data,
  input  logic                      rd_data_valid,
  output logic [MEM_DATA_WIDTH-1:0] weight_and_bias_data,
  output logic                      weight_and_bias_valid,
  input  logic                      weight_buffer_ready
`ifdef WEIGHT_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               perf_beat_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  localparam int unsigned BYTES_PER_BEAT = bytes_per_beat(MEM_DATA_WIDTH);

  fetch_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [BEAT_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                      rd_cmd_valid_q, rd_cmd_valid_d;
  logic [ADDR_WIDTH-1:0]     rd_cmd_addr_q, rd_cmd_addr_d;
  logic [LEN_WIDTH-1:0]      rd_cmd_len_q, rd_cmd_len_d;
  logic                      wab_valid_q, wab_valid_d;
  logic [MEM_DATA_WIDTH-1:0] wab_data_q, wab_data_d;
  logic                      fetch_done_q, fetch_done_d;

  logic [LEN_WIDTH-1:0]      next_len;
  logic                      cmd_fire;
  logic                      can_issue;
  logic                      ret_accept;
  logic                      credit_empty;
  logic                      launch_ok;
  logic                      start_accept;

  assign next_len     = (remaining_q >= BEAT_CNT_WIDTH'(BURST_LEN)) ? LEN_WIDTH'(BURST_LEN)
                                                                     : LEN_WIDTH'(remaining_q);
  assign cmd_fire     = rd_cmd_valid_q && rd_cmd_ready;
  assign launch_ok    = weight_buffer_ready && can_issue;
  assign start_accept = (state_q == ST_IDLE) && fetch_start;

  weight_fetch_credit #(
    .LEN_WIDTH      (LEN_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk         (system_clk),
    .rst_n       (rst_n),
    .cmd_fire    (cmd_fire),
    .cmd_len     (rd_cmd_len_q),
    .ret_valid   (rd_data_valid),
    .query_len   (next_len),
    .can_issue   (can_issue),
    .ret_accept  (ret_accept),
    .credit_empty(credit_empty)
  );

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    remaining_d    = remaining_q;
    rd_cmd_valid_d = rd_cmd_valid_q;
    rd_cmd_addr_d  = rd_cmd_addr_q;
    rd_cmd_len_d   = rd_cmd_len_q;
    fetch_done_d   = 1'b0;
    wab_valid_d    = ret_accept;
    wab_data_d     = ret_accept ? rd_data : wab_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          cur_addr_d  = fetch_base_addr;
          remaining_d = fetch_beat_num;
          state_d     = (fetch_beat_num == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A presented command is held until accepted, regardless of buffer/credit changes.
        if (rd_cmd_valid_q) begin
          if (rd_cmd_ready) begin
            rd_cmd_valid_d = 1'b0;
            cur_addr_d     = cur_addr_q + ADDR_WIDTH'(rd_cmd_len_q) * ADDR_WIDTH'(BYTES_PER_BEAT);
            remaining_d    = remaining_q - BEAT_CNT_WIDTH'(rd_cmd_len_q);
            if (remaining_d == '0) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (launch_ok) begin
          rd_cmd_valid_d = 1'b1;
          rd_cmd_addr_d  = cur_addr_q;
          rd_cmd_len_d   = next_len;
        end
      end
      ST_DRAIN: begin
        if (credit_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fetch_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cur_addr_q     <= '0;
      remaining_q    <= '0;
      rd_cmd_valid_q <= 1'b0;
      rd_cmd_addr_q  <= '0;
      rd_cmd_len_q   <= '0;
      wab_valid_q    <= 1'b0;
      wab_data_q     <= '0;
      fetch_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      remaining_q    <= remaining_d;
      rd_cmd_valid_q <= rd_cmd_valid_d;
      rd_cmd_addr_q  <= rd_cmd_addr_d;
      rd_cmd_len_q   <= rd_cmd_len_d;
      wab_valid_q    <= wab_valid_d;
      wab_data_q     <= wab_data_d;
      fetch_done_q   <= fetch_done_d;
    end
  end

  assign fetch_busy            = (state_q != ST_IDLE);
  assign fetch_done            = fetch_done_q;
  assign rd_cmd_valid          = rd_cmd_valid_q;
  assign rd_cmd_addr           = rd_cmd_addr_q;
  assign rd_cmd_len            = rd_cmd_len_q;
  assign weight_and_bias_valid = wab_valid_q;
  assign weight_and_bias_data  = wab_data_q;

`ifdef WEIGHT_FETCH_PERF_CNT_EN
  logic [31:0] perf_beat_q, perf_beat_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_cycle;

  assign stall_cycle = (state_q == ST_ISSUE) && !rd_cmd_valid_q && !launch_ok;

  always_comb begin
    perf_beat_d  = perf_beat_q;
    perf_stall_d = perf_stall_q;
    if (start_accept) begin
      perf_beat_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (wab_valid_d) perf_beat_d = perf_beat_q + 32'd1;
      if (stall_cycle) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beat_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_beat_q  <= perf_beat_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_beat_cnt  = perf_beat_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_weight_bias_fetcher.sv
// Directed self-checking bench for weight_bias_fetcher with a small memory model that
// logs commands, returns requested beats in order, and predicts forwarding.
module tb_weight_bias_fetcher;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 20;
  localparam int unsigned LW = 8;

  logic          system_clk;
  logic          rst_n;
  logic          fetch_start;
  logic [AW-1:0] fetch_base_addr;
  logic [BW-1:0] fetch_beat_num;
  logic          fetch_busy;
  logic          fetch_done;
  logic          rd_cmd_valid;
  logic          rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr;
  logic [LW-1:0] rd_cmd_len;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [DW-1:0] weight_and_bias_data;
  logic          weight_and_bias_valid;
  logic          weight_buffer_ready;

  weight_bias_fetcher #(
    .MEM_DATA_WIDTH (DW),
    .ADDR_WIDTH     (AW),
    .BEAT_CNT_WIDTH (BW),
    .LEN_WIDTH      (LW),
    .BURST_LEN      (16),
    .MAX_OUTSTANDING(32)
  ) dut (
    .system_clk           (system_clk),
    .rst_n                (rst_n),
    .fetch_start          (fetch_start),
    .fetch_base_addr      (fetch_base_addr),
    .fetch_beat_num       (fetch_beat_num),
    .fetch_busy           (fetch_busy),
    .fetch_done           (fetch_done),
    .rd_cmd_valid         (rd_cmd_valid),
    .rd_cmd_ready         (rd_cmd_ready),
    .rd_cmd_addr          (rd_cmd_addr),
    .rd_cmd_len           (rd_cmd_len),
    .rd_data              (rd_data),
    .rd_data_valid        (rd_data_valid),
    .weight_and_bias_data (weight_and_bias_data),
    .weight_and_bias_valid(weight_and_bias_valid),
    .weight_buffer_ready  (weight_buffer_ready)
  );

  initial begin
    system_clk = 1'b0;
    forever #5 system_clk = ~system_clk;
  end

  int n_checks;
  int n_fail;
  int mem_pending, mdl_out, data_seq, returned, fwd_cnt, done_cnt, sim_hs_cnt;
  int cmd_n, cmd_base, third_ret;
  logic [AW-1:0] cmd_addr_log [16];
  logic [LW-1:0] cmd_len_log  [16];
  logic          mem_en, prev_rdv, prev_accept;
  logic [DW-1:0] prev_data;
  int c0, f0, d0, r0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_pattern(input int seq);
    logic [31:0] w;
    w = 32'(seq) ^ 32'hA5A5_0000;
    return {16{w}};
  endfunction

  // One clock: check what the last edge produced, then drive memory for the next edge.
  task automatic step();
    logic          hs, rdv, acc;
    logic [DW-1:0] d;
    @(negedge system_clk);
    check("fwd_valid", 64'(weight_and_bias_valid), 64'(prev_rdv && prev_accept));
    if (prev_rdv && prev_accept && weight_and_bias_valid) begin
      n_checks++;
      assert (weight_and_bias_data === prev_data) else begin
        n_fail++;
        $error("FAIL fwd_data observed=%0h expected=%0h", weight_and_bias_data[63:0], prev_data[63:0]);
      end
      fwd_cnt++;
    end
    if (fetch_done === 1'b1) done_cnt++;
    hs  = rd_cmd_valid && rd_cmd_ready;
    rdv = mem_en && (mem_pending > 0);
    acc = rdv && (mdl_out > 0);
    d   = rdv ? beat_pattern(data_seq) : '0;
    if (hs) begin
      if (cmd_n < 16) begin
        cmd_addr_log[cmd_n] = rd_cmd_addr;
        cmd_len_log[cmd_n]  = rd_cmd_len;
      end
      if (cmd_n == cmd_base + 2) third_ret = returned;
      if (acc) sim_hs_cnt++;
      cmd_n++;
      mem_pending += int'(rd_cmd_len);
      mdl_out     += int'(rd_cmd_len);
    end
    if (rdv) begin
      mem_pending--;
      data_seq++;
      returned++;
    end
    if (acc) mdl_out--;
    rd_data_valid = rdv;
    rd_data       = d;
    prev_rdv      = rdv;
    prev_accept   = acc;
    prev_data     = d;
  endtask

  task automatic run_to_done(input string tag, input int bound);
    int start_done;
    start_done = done_cnt;
    for (int i = 0; i < bound && done_cnt == start_done; i++) step();
    check(tag, 64'(done_cnt - start_done), 64'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    mem_pending = 0; mdl_out = 0; data_seq = 0; returned = 0; fwd_cnt = 0;
    done_cnt = 0; sim_hs_cnt = 0; cmd_n = 0; cmd_base = 0; third_ret = -1;
    mem_en = 1'b0; prev_rdv = 1'b0; prev_accept = 1'b0; prev_data = '0;
    rst_n = 1'b0; fetch_start = 1'b0; fetch_base_addr = '0; fetch_beat_num = '0;
    rd_cmd_ready = 1'b1; rd_data = '0; rd_data_valid = 1'b0; weight_buffer_ready = 1'b1;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_busy", 64'(fetch_busy), 64'd0);
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_cmd_valid", 64'(rd_cmd_valid), 64'd0);
    check("rst_cmd_addr", 64'(rd_cmd_addr), 64'd0);
    check("rst_cmd_len", 64'(rd_cmd_len), 64'd0);

    // 40 beats from 0x1000 with always-ready memory
    mem_en = 1'b1; c0 = cmd_n; f0 = fwd_cnt; cmd_base = cmd_n; sim_hs_cnt = 0;
    fetch_base_addr = 32'h1000; fetch_beat_num = 20'd40; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("t1_busy", 64'(fetch_busy), 64'd1);
    run_to_done("t1_done", 400);
    check("t1_cmd_count", 64'(cmd_n - c0), 64'd3);
    check("t1_cmd0_addr", 64'(cmd_addr_log[c0]), 64'h1000);
    check("t1_cmd0_len", 64'(cmd_len_log[c0]), 64'd16);
    check("t1_cmd1_addr", 64'(cmd_addr_log[c0+1]), 64'h1400);
    check("t1_cmd1_len", 64'(cmd_len_log[c0+1]), 64'd16);
    check("t1_cmd2_addr", 64'(cmd_addr_log[c0+2]), 64'h1800);
    check("t1_cmd2_len", 64'(cmd_len_log[c0+2]), 64'd8);
    check("t1_fwd_count", 64'(fwd_cnt - f0), 64'd40);
    check("t1_hs_with_return", 64'(sim_hs_cnt > 0), 64'd1);
    step();
    check("t1_done_one_cycle", 64'(fetch_done), 64'd0);
    check("t1_idle_busy", 64'(fetch_busy), 64'd0);

    // Zero-length fetch
    c0 = cmd_n;
    fetch_base_addr = 32'h5000; fetch_beat_num = 20'd0; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("t2_done_c1", 64'(fetch_done), 64'd0);
    check("t2_busy_c1", 64'(fetch_busy), 64'd1);
    check("t2_cmd_valid", 64'(rd_cmd_valid), 64'd0);
    step();
    check("t2_done_c2", 64'(fetch_done), 64'd1);
    check("t2_busy_c2", 64'(fetch_busy), 64'd0);
    step();
    check("t2_done_c3", 64'(fetch_done), 64'd0);
    check("t2_no_cmds", 64'(cmd_n - c0), 64'd0);

    // Buffer almost-full before the first command
    c0 = cmd_n; f0 = fwd_cnt; weight_buffer_ready = 1'b0;
    fetch_base_addr = 32'h2000; fetch_beat_num = 20'd16; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_held_cmd_valid", 64'(rd_cmd_valid), 64'd0);
    end
    check("t3_held_busy", 64'(fetch_busy), 64'd1);
    weight_buffer_ready = 1'b1;
    step();
    check("t3_release_cmd_valid", 64'(rd_cmd_valid), 64'd1);
    check("t3_release_addr", 64'(rd_cmd_addr), 64'h2000);
    check("t3_release_len", 64'(rd_cmd_len), 64'd16);
    run_to_done("t3_done", 200);
    check("t3_fwd_count", 64'(fwd_cnt - f0), 64'd16);

    // Credit limit: returns withheld, 64 beats with 32 beats of credit
    mem_en = 1'b0; c0 = cmd_n; f0 = fwd_cnt; r0 = returned; cmd_base = cmd_n; third_ret = -1;
    fetch_base_addr = 32'h0; fetch_beat_num = 20'd64; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (30) step();
    check("t4_cmds_before_data", 64'(cmd_n - c0), 64'd2);
    check("t4_blocked_valid", 64'(rd_cmd_valid), 64'd0);
    check("t4_no_returns", 64'(returned - r0), 64'd0);
    mem_en = 1'b1;
    run_to_done("t4_done", 400);
    check("t4_third_after_16", 64'(third_ret >= r0 + 16), 64'd1);
    check("t4_cmd_count", 64'(cmd_n - c0), 64'd4);
    check("t4_cmd3_addr", 64'(cmd_addr_log[c0+3]), 64'h0C00);
    check("t4_fwd_count", 64'(fwd_cnt - f0), 64'd64);

    // Reset mid-DRAIN with 5 beats in flight
    mem_en = 1'b0; c0 = cmd_n; f0 = fwd_cnt; r0 = returned; d0 = done_cnt;
    fetch_base_addr = 32'h3000; fetch_beat_num = 20'd16; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 20 && cmd_n == c0; i++) step();
    check("t6_cmd_issued", 64'(cmd_n - c0), 64'd1);
    step();
    mem_en = 1'b1;
    for (int i = 0; i < 40 && returned < r0 + 11; i++) step();
    mem_en = 1'b0;
    step();
    step();
    check("t6_fwd_before_rst", 64'(fwd_cnt - f0), 64'd11);
    check("t6_busy_before_rst", 64'(fetch_busy), 64'd1);
    check("t6_in_flight", 64'(mem_pending), 64'd5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(fetch_busy), 64'd0);
    check("t6_rst_cmd_valid", 64'(rd_cmd_valid), 64'd0);
    check("t6_rst_wab_valid", 64'(weight_and_bias_valid), 64'd0);
    check("t6_rst_done", 64'(fetch_done), 64'd0);
    mdl_out = 0; prev_rdv = 1'b0; prev_accept = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    mem_en = 1'b1;
    repeat (12) step();
    check("t6_stale_dropped", 64'(fwd_cnt - f0), 64'd11);
    check("t6_stale_drained", 64'(mem_pending), 64'd0);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_idle_busy", 64'(fetch_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bias_fetcher.md
Name: weight_bias_fetcher

Overview:
- Transmit-side engine for the weight/bias stream into the weight buffer.
- On a start pulse, it fetches a contiguous region of weight/bias beats from external memory as read bursts.
- Forwards each returned beat on weight_and_bias_data/valid, throttled by the buffer's weight_buffer_ready (almost-full) flag.
- Sits between the layer controller and the memory read port, ahead of the weight buffer.

Parameters:
- MEM_DATA_WIDTH, `MEM_DATA_WIDTH (512): beat width in bits; one beat = MEM_DATA_WIDTH/8 bytes.
- ADDR_WIDTH, 32: byte address width.
- BEAT_CNT_WIDTH, 20: width of the total-beat count.
- LEN_WIDTH, 8: burst length field width.
- BURST_LEN, 16: maximum beats per read command (1..2^LEN_WIDTH-1).
- MAX_OUTSTANDING, 64: maximum requested-but-not-returned beats (≥ BURST_LEN).

Ports:
- system_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_start  in  1  single-cycle start request
- fetch_base_addr  in  ADDR_WIDTH  byte start address, beat-aligned
- fetch_beat_num  in  BEAT_CNT_WIDTH  total beats to fetch
- fetch_busy  out  1  high from accepted start until done
- fetch_done  out  1  one-cycle completion pulse
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read command accepted
- rd_cmd_addr  out  ADDR_WIDTH  burst byte address
- rd_cmd_len  out  LEN_WIDTH  burst beat count (1..BURST_LEN)
- rd_data  in  MEM_DATA_WIDTH  returned beat
- rd_data_valid  in  1  returned beat valid (no backpressure)
- weight_and_bias_data  out  MEM_DATA_WIDTH  beat to weight buffer
- weight_and_bias_valid  out  1  beat valid to weight buffer
- weight_buffer_ready  in  1  buffer not almost-full

Behaviour:
- Clock and reset: single clock system_clk; rst_n asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states:
  - IDLE: fetch_start=1 latches base addr and beat count, then goes to ISSUE. If fetch_beat_num==0, goes to DONE instead and issues no commands.
  - ISSUE: computes the next command and drives rd_cmd_valid. It may assert only when weight_buffer_ready=1 and outstanding+len ≤ MAX_OUTSTANDING.
    - Once asserted, rd_cmd_valid/addr/len stay stable until rd_cmd_ready (AXI-style; not retracted even if weight_buffer_ready falls).
    - On handshake: addr += len*(MEM_DATA_WIDTH/8), remaining -= len. When remaining reaches 0, goes to DRAIN.
  - DRAIN: waits until outstanding==0 and the last beat has been forwarded, then goes to DONE.
  - DONE: fetch_done=1 for exactly one cycle, then IDLE.
- Burst length: len = min(BURST_LEN, remaining). The last burst may be short. No 4 KB boundary splitting.
- Outstanding counter: += len on command handshake, −1 per rd_data_valid. A simultaneous handshake and return applies len−1 net.
- Data path: rd_data_valid at cycle t gives weight_and_bias_valid and weight_and_bias_data (registered copy) at cycle t+1. No reordering, no width change.
- Stray returns: rd_data_valid with outstanding==0 is ignored and not forwarded. This covers stale data after a mid-operation reset.
- fetch_busy=1 in ISSUE, DRAIN and DONE. fetch_start while busy is ignored.
- Buffer margin (system requirement): the buffer's prog_full threshold must leave ≥ MAX_OUTSTANDING+1 free entries. The fetcher never drops or stalls returned data.
- Reset mid-operation: all state clears immediately, no done pulse, pending command dropped.

Optional Feature:
- Macro: WEIGHT_FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_beat_cnt (32b) and perf_stall_cnt (32b). Both clear on an accepted fetch_start.
  - perf_beat_cnt counts forwarded beats.
  - perf_stall_cnt counts ISSUE cycles in which a command is pending but blocked by weight_buffer_ready=0 or the credit limit.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared header/package holds the FSM state encoding (IDLE, ISSUE, DRAIN, DONE) and the bytes-per-beat constant derived from MEM_DATA_WIDTH.
- One sub-module, weight_fetch_credit: the outstanding-beat counter with a can_issue(len) comparison.

Test Plan:
- base=0x1000, beats=40, BURST_LEN=16, always-ready memory → commands (0x1000,16), (0x1400,16), (0x1800,8); 40 beats forwarded in order, each 1 cycle after rd_data_valid; one fetch_done.
- beats=0 → no rd_cmd_valid; fetch_done pulses 2 cycles after start.
- weight_buffer_ready held 0 before the first command → no rd_cmd_valid. Release → first command issues the next cycle; perf_stall_cnt equals the held cycles when the macro is enabled.
- Memory delays all returns; MAX_OUTSTANDING=32, BURST_LEN=16, beats=64 → exactly 2 commands issued before any data; the 3rd issues only after ≥16 beats return.
- Command accepted in the same cycle as a data return → outstanding changes by len−1; the final count reaches 0 and done fires.
- rst_n pulled low mid-DRAIN with 5 beats in flight → outputs 0 immediately; the late 5 beats are not forwarded; no fetch_done.
